// File: rtl/alu_operand_entry.sv
// ============================================================================
// alu_operand_entry: debounced operand/op entry with sequential saturating ALU
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_operand_entry #(
  parameter int DEBOUNCE_CYCLES = 100_000,
  parameter int MAX_DISPLAY     = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  input  logic [1:0] op,
  input  logic       btn_enter,
  input  logic       btn_clear,
  output logic [7:0] alu_result,
  output logic       ovf,
  output logic       busy,
  output logic [1:0] state
);

  localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]      MAX_RAW = 16'(MAX_DISPLAY);
  localparam logic [7:0]       MAX_OUT = 8'(MAX_DISPLAY);

  typedef enum logic [1:0] {
    S_LOAD_A = 2'b00,
    S_LOAD_B = 2'b01,
    S_EXEC   = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  logic [1:0] btn_raw;
  logic [1:0] press;
  logic       enter_press;
  logic       clear_press;

  assign btn_raw     = {btn_clear, btn_enter};
  assign enter_press = press[0];
  assign clear_press = press[1];

  // Counter runs only while the synced input disagrees with the accepted level
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic             sync1_q, sync2_q, level_q, press_q;
    logic             level_d, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      press_d = 1'b0;
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_MAX) begin
          level_d = sync2_q;
          press_d = sync2_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        cnt_q   <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
      end else begin
        sync1_q <= btn_raw[i];
        sync2_q <= sync1_q;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        press_q <= press_d;
      end
    end

    assign press[i] = press_q;
  end

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] acc_q, acc_d;
  logic [2:0]  mcnt_q, mcnt_d;
  logic [7:0]  result_q, result_d;
  logic        ovf_q, ovf_d;
  logic        busy_q, busy_d;

  logic [15:0] mul_term;
  logic [15:0] acc_next;
  logic [15:0] raw;
  logic        sub_uf;
  logic        finish;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mcnt_d   = mcnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    raw      = '0;
    sub_uf   = 1'b0;
    finish   = 1'b0;
    mul_term = b_q[mcnt_q] ? ({8'd0, a_q} << mcnt_q) : 16'd0;
    acc_next = acc_q + mul_term;

    case (state_q)
      S_LOAD_A: begin
        if (enter_press) begin
          a_d     = sw;
          state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (enter_press) begin
          b_d     = sw;
          op_d    = op;
          acc_d   = '0;
          mcnt_d  = '0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_q)
          2'b00: begin
            raw    = {8'd0, a_q} + {8'd0, b_q};
            finish = 1'b1;
          end
          2'b01: begin
            sub_uf = (b_q > a_q);
            raw    = {8'd0, a_q - b_q};
            finish = 1'b1;
          end
          2'b10: begin
            // Shift-add, one multiplier bit per cycle, LSB first
            acc_d  = acc_next;
            mcnt_d = mcnt_q + 3'd1;
            raw    = acc_next;
            finish = (mcnt_q == 3'd7);
          end
          default: begin
            raw    = {8'd0, a_q & b_q};
            finish = 1'b1;
          end
        endcase
        if (finish) begin
          state_d = S_DONE;
          if (sub_uf) begin
            result_d = 8'd0;
            ovf_d    = 1'b1;
          end else if (raw > MAX_RAW) begin
            result_d = MAX_OUT;
            ovf_d    = 1'b1;
          end else begin
            result_d = raw[7:0];
            ovf_d    = 1'b0;
          end
        end
      end
      default: begin
        if (enter_press) begin
          state_d = S_LOAD_A;
        end
      end
    endcase

    // Clear overrides every other update, including a completing operation
    if (clear_press) begin
      state_d  = S_LOAD_A;
      result_d = 8'd0;
      ovf_d    = 1'b0;
      acc_d    = '0;
      mcnt_d   = '0;
    end

    busy_d = (state_d == S_EXEC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_LOAD_A;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      mcnt_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      mcnt_q   <= mcnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
    end
  end

  assign alu_result = result_q;
  assign ovf        = ovf_q;
  assign busy       = busy_q;
  assign state      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_entry.sv
// ============================================================================
// tb_alu_operand_entry: scoreboard bench for alu_operand_entry (debounce = 4)
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_operand_entry;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic [1:0] op;
  logic       btn_enter;
  logic       btn_clear;
  logic [7:0] alu_result;
  logic       ovf;
  logic       busy;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] res;
    logic       ovf;
    int         busy;
  } exp_t;

  exp_t exp_q[$];

  alu_operand_entry #(
    .DEBOUNCE_CYCLES(4),
    .MAX_DISPLAY    (99)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .op        (op),
    .btn_enter (btn_enter),
    .btn_clear (btn_clear),
    .alu_result(alu_result),
    .ovf       (ovf),
    .busy      (busy),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold a button high for n cycles, then low long enough for the release to settle
  task automatic press(input bit clr, input int n);
    if (clr) btn_clear = 1'b1;
    else     btn_enter = 1'b1;
    tick(n);
    if (clr) btn_clear = 1'b0;
    else     btn_enter = 1'b0;
    tick(12);
  endtask

  task automatic wait_state(input logic [1:0] s, input string name);
    int n;
    n = 0;
    while (state !== s && n < 40) begin
      tick(1);
      n++;
    end
    chk(name, state, s);
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o,
                       input logic [7:0] res, input logic ov, input int bz);
    exp_t e;
    sw = a;
    press(1'b0, 8);
    chk("a_entered_state", state, 2'b01);
    sw = b;
    op = o;
    e.res = res;
    e.ovf = ov;
    e.busy = bz;
    exp_q.push_back(e);
    press(1'b0, 8);
    wait_state(2'b11, "done_state");
    press(1'b0, 8);
    chk("next_load_a_state", state, 2'b00);
    chk("result_held", alu_result, res);
    chk("ovf_held", ovf, ov);
  endtask

  // Monitor: scores each EXEC->DONE completion against the queued expectation
  logic [1:0] mon_prev = 2'b00;
  int         mon_bcnt = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_prev = 2'b00;
        mon_bcnt = 0;
      end else begin
        if (busy) mon_bcnt++;
        if (mon_prev == 2'b10 && state == 2'b11) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got %0d expected no completion", alu_result);
          end else begin
            e = exp_q.pop_front();
            chk("result", alu_result, e.res);
            chk("ovf", ovf, e.ovf);
            chk("busy_cycles", mon_bcnt, e.busy);
          end
          mon_bcnt = 0;
        end else if (state != 2'b10) begin
          mon_bcnt = 0;
        end
        mon_prev = state;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    sw = 8'd0;
    op = 2'b00;
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      btn_enter = i[0];
      btn_clear = ~i[0];
      tick(1);
    end
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    tick(2);
    chk("reset_state", state, 2'b00);
    chk("reset_result", alu_result, 8'd0);
    chk("reset_ovf", ovf, 1'b0);
    chk("reset_busy", busy, 1'b0);
    rst = 1'b0;
    tick(15);
    chk("post_reset_idle_state", state, 2'b00);

    do_op(8'd25,  8'd37,  2'b00, 8'd62, 1'b0, 1);
    do_op(8'd12,  8'd9,   2'b10, 8'd99, 1'b1, 8);
    do_op(8'd5,   8'd9,   2'b01, 8'd0,  1'b1, 1);
    do_op(8'd9,   8'd5,   2'b01, 8'd4,  1'b0, 1);
    do_op(8'd50,  8'd49,  2'b00, 8'd99, 1'b0, 1);
    do_op(8'd255, 8'd255, 2'b10, 8'd99, 1'b1, 8);
    do_op(8'd0,   8'd0,   2'b00, 8'd0,  1'b0, 1);
    do_op(8'd240, 8'd60,  2'b11, 8'd48, 1'b0, 1);
    do_op(8'd200, 8'd100, 2'b00, 8'd99, 1'b1, 1);
    do_op(8'd7,   8'd11,  2'b10, 8'd77, 1'b0, 8);

    sw = 8'd3;
    press(1'b0, 1);
    chk("glitch1_state", state, 2'b00);
    press(1'b0, 2);
    chk("glitch2_state", state, 2'b00);
    press(1'b0, 3);
    chk("glitch3_state", state, 2'b00);
    press(1'b0, 6);
    chk("press6_state", state, 2'b01);

    fork
      press(1'b0, 8);
      press(1'b1, 8);
    join
    chk("clear_enter_state", state, 2'b00);
    chk("clear_enter_result", alu_result, 8'd0);

    do_op(8'd25, 8'd37, 2'b00, 8'd62, 1'b0, 1);

    sw = 8'd12;
    press(1'b0, 8);
    chk("mul_a_state", state, 2'b01);
    sw = 8'd9;
    op = 2'b10;
    fork
      press(1'b0, 8);
      begin
        tick(3);
        press(1'b1, 8);
      end
      begin
        int n;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
          tick(1);
          n++;
        end
        chk("busy_during_mul", busy, 1'b1);
        chk("result_during_mul", alu_result, 8'd62);
      end
    join
    chk("abort_state", state, 2'b00);
    chk("abort_result", alu_result, 8'd0);
    chk("abort_ovf", ovf, 1'b0);
    chk("abort_busy", busy, 1'b0);

    do_op(8'd30, 8'd40, 2'b00, 8'd70, 1'b0, 1);

    tick(5);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
